// File: rtl/spi_bus_master.sv
// spi_bus_master: CPU-mapped SPI mode-0 master with control/status/data/chip-select registers
module spi_bus_master (
  input  logic       Clk,
  input  logic       Reset_H,
  input  logic       SPI_Enable_H,
  input  logic [3:0] Address,
  input  logic       RW,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       DTACK_L,
  output logic       IRQ_L,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] CS_L
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t st, nxt;
  logic en_q, spie, spe, spif, wcol;
  logic [1:0] div, div_q;
  logic [7:0] spcs, spdr_rx, tx, rx, rd;
  logic [3:0] cnt, h_last;
  logic [2:0] bit_cnt;
  logic acc, wr, wr_sr, start, done, half_done;
  assign IRQ_L = !(spif && spie);
  assign CS_L = spcs;
  // bus strobe edge detect, half-period timing, next shift state and read mux
  always_comb begin
    acc = SPI_Enable_H && !en_q;
    wr = acc && !RW;
    wr_sr = wr && Address == 4'h2;
    h_last = {div_q == 2'd3, div_q[1], div_q != 2'd0, 1'b1};
    half_done = cnt == h_last;
    start = wr && Address == 4'h4 && spe && st == IDLE;
    nxt = st;
    if (st != IDLE && !spe) nxt = IDLE;
    else if (start) nxt = LOW;
    else if (st == LOW && half_done) nxt = HIGH;
    else if (st == HIGH && half_done) nxt = bit_cnt == 3'd7 ? IDLE : LOW;
    done = st == HIGH && nxt == IDLE && spe;
    rd = Address == 4'h0 ? {spie, spe, 4'b0, div} :
         Address == 4'h2 ? {spif, wcol, 5'b0, st != IDLE} :
         Address == 4'h4 ? spdr_rx :
         Address == 4'h6 ? spcs : 8'h00;
  end
  // shift engine state register
  always_ff @(posedge Clk) begin
    if (Reset_H) st <= IDLE;
    else st <= nxt;
  end
  // registers, bus handshake and shift datapath
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      en_q <= 1'b1;
      DTACK_L <= 1'b1;
      DataOut <= 8'h00;
      {spie, spe, div} <= 4'h0;
      spcs <= 8'hFF;
      spif <= 1'b0;
      wcol <= 1'b0;
      spdr_rx <= 8'h00;
      SCLK <= 1'b0;
      MOSI <= 1'b0;
      cnt <= 4'd0;
      bit_cnt <= 3'd0;
      div_q <= 2'd0;
      tx <= 8'h00;
      rx <= 8'h00;
    end else begin
      en_q <= SPI_Enable_H;
      DTACK_L <= acc ? 1'b0 : !SPI_Enable_H ? 1'b1 : DTACK_L;
      DataOut <= SPI_Enable_H && RW ? rd : 8'h00;
      if (wr && Address == 4'h0) {spie, spe, div} <= {DataIn[7:6], DataIn[1:0]};
      if (wr && Address == 4'h6) spcs <= DataIn;
      spif <= done || (spif && !(wr_sr && DataIn[7]));
      wcol <= (wr && Address == 4'h4 && spe && st != IDLE) || (wcol && !(wr_sr && DataIn[6]));
      cnt <= nxt != st ? 4'd0 : cnt + 4'd1;
      if (done) spdr_rx <= rx;
      if (start) begin
        tx <= DataIn;
        MOSI <= DataIn[7];
        SCLK <= 1'b0;
        div_q <= div;
        bit_cnt <= 3'd0;
      end else if (nxt == IDLE) begin
        SCLK <= 1'b0;
        MOSI <= 1'b0;
      end else if (st == LOW && nxt == HIGH) begin
        SCLK <= 1'b1;
        rx <= {rx[6:0], MISO};
      end else if (st == HIGH && nxt == LOW) begin
        SCLK <= 1'b0;
        MOSI <= tx[6];
        tx <= {tx[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_bus_master.sv
// tb_spi_bus_master: randomized self-checking bench for spi_bus_master
module tb_spi_bus_master;
  logic Clk = 0, Reset_H = 1, SPI_Enable_H = 0, RW = 1;
  logic [3:0] Address = 0;
  logic [7:0] DataIn = 0, DataOut, CS_L;
  logic DTACK_L, IRQ_L, SCLK, MOSI, MISO;
  int checks = 0, errors = 0;
  int mon_rises = 0, rises_base = 0;
  logic [7:0] mon_byte = 0, pat = 0, last_rx = 0;
  logic loop_mode = 0;
  logic [2:0] idx;

  spi_bus_master dut (.Clk(Clk), .Reset_H(Reset_H), .SPI_Enable_H(SPI_Enable_H), .Address(Address),
    .RW(RW), .DataIn(DataIn), .DataOut(DataOut), .DTACK_L(DTACK_L), .IRQ_L(IRQ_L),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_L(CS_L));

  always #5 Clk = ~Clk;

  // slave side: record MOSI on each SCLK rise, answer with pat MSB first or echo MOSI
  always @(posedge SCLK) begin
    mon_byte <= {mon_byte[6:0], MOSI};
    mon_rises <= mon_rises + 1;
  end
  assign idx = 3'(mon_rises - rises_base);
  assign MISO = loop_mode ? MOSI : pat[~idx];

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge Clk); SPI_Enable_H = 1; RW = 0; Address = a; DataIn = d;
    do begin @(negedge Clk); n++; end while (DTACK_L !== 1'b0 && n < 5);
    checks++; if (DTACK_L !== 1'b0) begin errors++; $display("FAIL wr_dtack a=%h got %b want 0", a, DTACK_L); end
    SPI_Enable_H = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    int n = 0;
    @(negedge Clk); SPI_Enable_H = 1; RW = 1; Address = a;
    do begin @(negedge Clk); n++; end while (DTACK_L !== 1'b0 && n < 5);
    checks++; if (DTACK_L !== 1'b0) begin errors++; $display("FAIL rd_dtack a=%h got %b want 0", a, DTACK_L); end
    d = DataOut;
    SPI_Enable_H = 0;
  endtask

  task automatic xfer(input logic spie, input logic [1:0] dv, input logic [7:0] data, input logic lp, input logic [7:0] p);
    int h = 2 << dv, cyc = 0, last = 0, tog = 0, bad = 0;
    logic prev = 0;
    logic [7:0] r, exp_rx = lp ? data : p;
    loop_mode = lp; pat = p; rises_base = mon_rises;
    bus_write(4'h0, {spie, 1'b1, 4'b0, dv});
    bus_write(4'h4, data);
    while (tog < 16 && cyc < 600) begin
      @(negedge Clk); cyc++;
      if (SCLK !== prev) begin if (cyc - last != h) bad++; last = cyc; tog++; prev = SCLK; end
    end
    checks++; if (tog != 16) begin errors++; $display("FAIL xfer_edges got %0d want 16", tog); end
    checks++; if (bad != 0) begin errors++; $display("FAIL xfer_halfperiod bad=%0d want 0 h=%0d", bad, h); end
    checks++; if (last != 16 * h) begin errors++; $display("FAIL xfer_len got %0d want %0d", last, 16 * h); end
    checks++; if (IRQ_L !== !spie) begin errors++; $display("FAIL xfer_irq got %b want %b", IRQ_L, !spie); end
    checks++; if (mon_rises - rises_base != 8 || mon_byte !== data) begin errors++; $display("FAIL xfer_mosi got %h/%0d want %h/8", mon_byte, mon_rises - rises_base, data); end
    bus_read(4'h2, r);
    checks++; if (r !== 8'h80) begin errors++; $display("FAIL xfer_spsr got %h want 80", r); end
    bus_read(4'h4, r);
    checks++; if (r !== exp_rx) begin errors++; $display("FAIL xfer_spdr got %h want %h", r, exp_rx); end
    last_rx = exp_rx;
    bus_write(4'h2, 8'h80);
    @(negedge Clk);
    checks++; if (IRQ_L !== 1'b1) begin errors++; $display("FAIL xfer_irq_clr got %b want 1", IRQ_L); end
    bus_read(4'h2, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL xfer_spsr_clr got %h want 00", r); end
  endtask

  task automatic test_reset;
    logic [7:0] r;
    Reset_H = 1; repeat (3) @(negedge Clk);
    checks++; if ({DataOut, DTACK_L, IRQ_L, SCLK, MOSI, CS_L} !== {8'h00, 4'b1100, 8'hFF}) begin errors++;
      $display("FAIL reset_pins got %h %b%b%b%b %h", DataOut, DTACK_L, IRQ_L, SCLK, MOSI, CS_L); end
    Reset_H = 0;
    bus_read(4'h0, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_spcr got %h want 00", r); end
    bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_spsr got %h want 00", r); end
    bus_read(4'h4, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_spdr got %h want 00", r); end
    bus_read(4'h6, r); checks++; if (r !== 8'hFF) begin errors++; $display("FAIL reset_spcs got %h want ff", r); end
  endtask

  task automatic test_regs;
    logic [7:0] r, cr, cs, d;
    logic [3:0] bad_a;
    for (int i = 0; i < 6; i++) begin
      cr = 8'($urandom) & 8'hBF; cs = 8'($urandom); d = 8'($urandom);
      bad_a = 4'($urandom_range(0, 11)); if (bad_a inside {4'h0, 4'h2, 4'h4, 4'h6}) bad_a = bad_a + 4'h1;
      bus_write(4'h0, cr); bus_write(4'h6, cs); bus_write(bad_a, d); bus_write(4'h2, 8'hFF);
      bus_read(4'h0, r); checks++; if (r !== (cr & 8'hC3)) begin errors++; $display("FAIL regs_spcr got %h want %h", r, cr & 8'hC3); end
      bus_read(4'h6, r); checks++; if (r !== cs || CS_L !== cs) begin errors++; $display("FAIL regs_spcs got %h/%h want %h", r, CS_L, cs); end
      bus_read(bad_a, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL regs_hole a=%h got %h want 00", bad_a, r); end
      bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL regs_spsr got %h want 00", r); end
    end
  endtask

  task automatic test_transfers;
    xfer(1'b0, 2'd0, 8'hA5, 1'b1, 8'h00);
    xfer(1'b1, 2'd3, 8'($urandom), 1'b0, 8'hFF);
    for (int i = 0; i < 5; i++)
      xfer(1'($urandom), 2'($urandom_range(0, 2)), 8'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic test_wcol;
    logic [7:0] r, d1 = 8'($urandom), d2 = ~d1, p = 8'($urandom), cs = 8'($urandom);
    int n = 0;
    loop_mode = 0; pat = p; rises_base = mon_rises;
    bus_write(4'h0, 8'hC1);
    bus_write(4'h4, d1);
    bus_write(4'h6, cs);
    checks++; if (CS_L !== cs) begin errors++; $display("FAIL wcol_cs got %h want %h", CS_L, cs); end
    bus_write(4'h4, d2);
    bus_read(4'h2, r);
    checks++; if (r !== 8'h41) begin errors++; $display("FAIL wcol_spsr_busy got %h want 41", r); end
    while (IRQ_L !== 1'b0 && n < 200) begin @(negedge Clk); n++; end
    repeat (40) @(negedge Clk);
    checks++; if (mon_rises - rises_base != 8 || mon_byte !== d1) begin errors++; $display("FAIL wcol_mosi got %h/%0d want %h/8", mon_byte, mon_rises - rises_base, d1); end
    bus_read(4'h4, r); checks++; if (r !== p) begin errors++; $display("FAIL wcol_spdr got %h want %h", r, p); end
    bus_write(4'h2, 8'h00);
    bus_read(4'h2, r); checks++; if (r !== 8'hC0) begin errors++; $display("FAIL wcol_w0 got %h want c0", r); end
    bus_write(4'h2, 8'hC0);
    bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL wcol_clr got %h want 00", r); end
    last_rx = p;
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int n = 0;
    loop_mode = 0; pat = 8'($urandom); rises_base = mon_rises;
    bus_write(4'h0, 8'h42);
    bus_write(4'h4, 8'($urandom));
    while (mon_rises - rises_base < 3 && n < 200) begin @(negedge Clk); n++; end
    bus_write(4'h0, 8'h02);
    @(negedge Clk);
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", SCLK); end
    bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL abort_spsr got %h want 00", r); end
    bus_read(4'h4, r); checks++; if (r !== last_rx) begin errors++; $display("FAIL abort_spdr got %h want %h", r, last_rx); end
    bus_write(4'h4, 8'($urandom));
    repeat (150) @(negedge Clk);
    checks++; if (mon_rises - rises_base != 3) begin errors++; $display("FAIL abort_rises got %0d want 3", mon_rises - rises_base); end
    bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL spe0_spsr got %h want 00", r); end
  endtask

  task automatic test_long_strobe;
    logic [7:0] r, d = 8'($urandom);
    int low = 0;
    loop_mode = 1; rises_base = mon_rises;
    bus_write(4'h0, 8'hC0);
    @(negedge Clk); SPI_Enable_H = 1; RW = 0; Address = 4'h4; DataIn = d;
    repeat (10) begin @(negedge Clk); if (DTACK_L === 1'b0) low++; end
    SPI_Enable_H = 0;
    @(negedge Clk);
    checks++; if (low != 10 || DTACK_L !== 1'b1) begin errors++; $display("FAIL strobe_dtack got low=%0d end=%b want 10/1", low, DTACK_L); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL strobe_dataout got %h want 00", DataOut); end
    repeat (100) @(negedge Clk);
    checks++; if (mon_rises - rises_base != 8 || mon_byte !== d) begin errors++; $display("FAIL strobe_once got %h/%0d want %h/8", mon_byte, mon_rises - rises_base, d); end
    bus_read(4'h4, r); checks++; if (r !== d) begin errors++; $display("FAIL strobe_spdr got %h want %h", r, d); end
    bus_write(4'h2, 8'h80);
    bus_read(4'h8, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL strobe_off8 got %h want 00", r); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    int base;
    logic irq_seen = 0;
    loop_mode = 0; pat = 8'hFF; rises_base = mon_rises;
    bus_write(4'h6, 8'h3C);
    bus_write(4'h0, 8'hC3);
    bus_write(4'h4, 8'($urandom));
    repeat (40) @(negedge Clk);
    SPI_Enable_H = 1; RW = 1; Address = 4'h6;
    repeat (2) @(negedge Clk);
    checks++; if (DTACK_L !== 1'b0 || DataOut !== 8'h3C) begin errors++; $display("FAIL rstmid_access got %b/%h want 0/3c", DTACK_L, DataOut); end
    Reset_H = 1;
    @(negedge Clk);
    checks++; if ({DataOut, DTACK_L, IRQ_L, SCLK, MOSI, CS_L} !== {8'h00, 4'b1100, 8'hFF}) begin errors++;
      $display("FAIL rstmid_pins got %h %b%b%b%b %h", DataOut, DTACK_L, IRQ_L, SCLK, MOSI, CS_L); end
    Reset_H = 0; SPI_Enable_H = 0;
    base = mon_rises;
    repeat (300) begin @(negedge Clk); if (IRQ_L !== 1'b1) irq_seen = 1; end
    checks++; if (irq_seen || mon_rises != base) begin errors++; $display("FAIL rstmid_quiet got irq=%b rises=%0d want 0/0", irq_seen, mon_rises - base); end
    bus_read(4'h2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL rstmid_spsr got %h want 00", r); end
    bus_read(4'h0, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL rstmid_spcr got %h want 00", r); end
    bus_read(4'h4, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL rstmid_spdr got %h want 00", r); end
  endtask

  initial begin
    test_reset;
    test_regs;
    test_transfers;
    test_wcol;
    test_abort;
    test_long_strobe;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_bus_master.md
SPI_BUS_MASTER -- requirements
Module: spi_bus_master

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Reset_H  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: SPI_Enable_H  in  1  decoded select for 00408020-0040802F (already qualified with AS_L).
REQ-004 SHALL have ports: Address  in  4  CPU address bits [3:0].
REQ-005 SHALL have ports: RW  in  1  1 = CPU read, 0 = CPU write.
REQ-006 SHALL have ports: DataIn  in  8  CPU write data; DataOut  out  8  CPU read data.
REQ-007 SHALL have ports: DTACK_L  out  1  bus acknowledge, active low.
REQ-008 SHALL have ports: IRQ_L  out  1  interrupt request, active low.
REQ-009 SHALL have ports: SCLK  out  1; MOSI  out  1; MISO  in  1; CS_L  out  8  SPI bus.

Function
REQ-010 Register map on Address[3:0]: 0x0 SPCR, 0x2 SPSR, 0x4 SPDR, 0x6 SPCS; all other offsets SHALL read 0x00 and ignore writes.
REQ-011 SPCR SHALL be read/write: bit7 SPIE, bit6 SPE, bits[1:0] DIV; other bits read 0.
REQ-012 SPSR SHALL be: bit7 SPIF, bit6 WCOL, bit0 BUSY (read-only); writing 1 to bit7/bit6 SHALL clear that flag; writing 0 has no effect.
REQ-013 SPCS SHALL be read/write; CS_L SHALL equal SPCS directly (no decoding).
REQ-014 Access: register action SHALL occur exactly once per strobe, in the cycle after SPI_Enable_H is first sampled high (rising-edge detect).
REQ-015 DTACK_L SHALL go low in the same cycle as the register action and remain low until SPI_Enable_H is sampled low, then return high next cycle.
REQ-016 DataOut SHALL present the selected register while SPI_Enable_H=1 and RW=1, else 0x00.
REQ-017 SPDR write with SPE=1 and BUSY=0 SHALL load the TX shifter and start a transfer; with BUSY=1 SHALL set WCOL and be discarded; with SPE=0 SHALL be discarded without WCOL.
REQ-018 SPDR read SHALL return the last fully received byte.
REQ-019 Shift engine states: IDLE, LOW, HIGH; SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8 bits.
REQ-020 Half-period H SHALL be 2, 4, 8, 16 Clk cycles for DIV = 00, 01, 10, 11; DIV SHALL be latched at transfer start.
REQ-021 On start: MOSI=bit7 of data, SCLK=0, enter LOW, BUSY=1.
REQ-022 LOW->HIGH after H cycles: SCLK=1, MISO sampled into RX shifter LSB.
REQ-023 HIGH->LOW after H cycles: SCLK=0, MOSI=next bit; after the 8th HIGH phase go to IDLE instead.
REQ-024 On entering IDLE from HIGH: SPDR receive = RX shifter, SPIF=1, BUSY=0; total 16*H Clk cycles from start cycle to SPIF set.
REQ-025 Idle levels: SCLK=0, MOSI=0.
REQ-026 SPE cleared mid-transfer SHALL abort to IDLE next cycle: SCLK=0, BUSY=0, SPIF unchanged, SPDR receive unchanged.
REQ-027 SPIF set by hardware and cleared by CPU in same cycle: set SHALL win; same rule for WCOL.
REQ-028 IRQ_L SHALL equal NOT(SPIF AND SPIE), combinationally from registered state.
REQ-029 SPCS writes during a transfer SHALL take effect immediately and SHALL NOT disturb the transfer.

Reset
REQ-030 Reset_H=1 at a rising edge SHALL set: SPCR=0x00, SPSR=0x00, SPDR receive=0x00, SPCS=0xFF, state=IDLE, SCLK=0, MOSI=0, DTACK_L=1, IRQ_L=1, DataOut=0x00.
REQ-031 Reset SHALL abort any in-progress transfer and bus acknowledge; no SPIF SHALL follow.

Verification
REQ-032 Write SPCR=0x40, SPDR=0xA5, MISO loopback from MOSI, DIV=00 -> SCLK 8 pulses each 4 Clk period, SPIF=1 at 32 Clk after start, SPDR reads 0xA5.
REQ-033 SPCR=0xC3, transfer with MISO=1 constant -> H=16, SPIF at 256 Clk, IRQ_L low, SPDR=0xFF; write SPSR=0x80 -> IRQ_L high.
REQ-034 Second SPDR write during BUSY -> SPSR=0x41 while busy, first transfer completes unchanged, data of second write never appears on MOSI.
REQ-035 Clear SPE at bit 3 of a transfer -> SCLK low and BUSY=0 next cycle, SPIF stays 0, SPDR receive retains prior value.
REQ-036 Hold SPI_Enable_H high 10 cycles on SPDR write -> exactly one transfer started, DTACK_L low 10 cycles then high one cycle after enable falls; read of offset 0x8 -> 0x00.
REQ-037 Assert Reset_H mid-transfer and mid-access -> all outputs at REQ-030 values next cycle, CS_L=0xFF.
